uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte the receiver flags with a single-cycle valid pulse, stores up to DEPTH bytes in a circular buffer, and presents them to the consumer (CPU bus bridge or command parser) on a first-word-fall-through valid/ready interface. It also reports fill level and a sticky overflow flag, because the receiver has no backpressure.

## Interface
- DEPTH_LOG2, default 4: log2 of buffer depth; DEPTH = 2**DEPTH_LOG2; legal range 1..8.
- clk  input  1  system clock; same clock that drives the UART receiver.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  received byte; sampled only when in_valid=1.
- in_valid  input  1  single-cycle pulse from the receiver; no ready path back.
- out_data  output  8  byte at head of buffer; meaningful only when out_valid=1.
- out_valid  output  1  buffer non-empty.
- out_ready  input  1  consumer accepts head byte when out_valid=1.
- level  output  DEPTH_LOG2+1  number of stored bytes, 0..DEPTH.
- full  output  1  level==DEPTH.
- empty  output  1  level==0.
- overflow  output  1  sticky; set when a byte arrives while full.
- overflow_clr  input  1  clears overflow.

## Operation
- Storage: DEPTH x 8 array, write pointer wr_ptr and read pointer rd_ptr, each DEPTH_LOG2 bits, wrapping modulo DEPTH; separate level counter, DEPTH_LOG2+1 bits.
- push = in_valid. pop = out_valid & out_ready. A pop with out_valid=0 is ignored.
- Push while not full: write in_data at wr_ptr, wr_ptr+1, level+1.
- Pop: rd_ptr+1, level-1.
- Push and pop in the same cycle: both take effect and level is unchanged. This includes the full case, which is not an overflow, and the level==1 case, where the new byte becomes head next cycle.
- Push while full without pop: byte dropped, pointers and level unchanged, overflow<=1.
- out_data = mem[rd_ptr], first-word-fall-through. Head is visible whenever out_valid=1, with no read request needed.
- overflow: set has priority over overflow_clr in the same cycle; otherwise overflow_clr=1 clears it.
- level, full, empty and out_valid are registered, or derived from registered state, and never combinationally depend on in_valid or out_ready.
- Reset (rst=1 at a clk edge): wr_ptr=0, rd_ptr=0, level=0, out_valid=0, empty=1, full=0, overflow=0. out_data reads 0x00 while empty after reset: mem is cleared, or the output is gated. Reset mid-operation discards all stored bytes. A push coinciding with rst is discarded.

## Timing
- Latency from push to visibility: in_valid at edge N with buffer empty gives out_valid=1 and out_data=in_data after edge N, so data is usable in cycle N+1.
- Pop at edge N: next head is on out_data after edge N with no bubble. Back-to-back pops every cycle are sustained.
- Throughput: one push and one pop per cycle.
- level, full, empty and overflow update on the same edge as the causing push or pop.
- in_valid is assumed to be at most 1 cycle wide per byte; each asserted cycle is a distinct byte.

## Configuration
- UART_RX_FIFO_OVERWRITE_EN: when defined, a push while full without a pop overwrites the oldest byte. The new byte is written at wr_ptr, both wr_ptr and rd_ptr advance, level stays DEPTH, and overflow<=1. The buffer therefore always holds the newest DEPTH bytes.
- When not defined, the default is drop-newest as described in Operation.

## Test plan
- Reset/idle: assert rst for 2 cycles, then release -> level=0, empty=1, full=0, out_valid=0, overflow=0, out_data=0x00.
- Single byte: push 0xA5 with out_ready=0 -> next cycle out_valid=1, out_data=0xA5, level=1. Then out_ready=1 for 1 cycle -> out_valid=0, empty=1.
- Fill/wrap (DEPTH=16): push 0x00..0x0F -> full=1, level=16. Pop 4 bytes, reading 0x00..0x03; push 0x10..0x13 -> full=1. Drain -> read sequence 0x04..0x13 in order with no bubbles.
- Overflow, default build: fill with 0x00..0x0F, push 0xEE -> overflow=1, level=16, drain reads 0x00..0x0F. Pulse overflow_clr together with another push while full -> overflow stays 1. Pulse overflow_clr alone -> overflow=0.
- Overflow with UART_RX_FIFO_OVERWRITE_EN: same stimulus -> overflow=1, level=16, drain reads 0x01..0x0F then 0xEE.
- Simultaneous push/pop: while full, out_ready=1 and push 0x55 in the same cycle -> overflow stays 0, level=16, 0x55 appears last. Assert rst mid-drain -> empty=1 on the next cycle, and a push in the rst cycle is not stored.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind a UART receiver.
// Captures single-cycle in_valid pulses into a DEPTH-entry circular buffer and
// presents the oldest byte on a first-word-fall-through valid/ready interface,
// along with a fill level and a sticky overflow flag.
// Optional feature macro: UART_RX_FIFO_OVERWRITE_EN. When it is defined, a push
// into a full buffer overwrites the oldest byte. By default the newest byte is
// dropped.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_LOG2:0]   level_reg, level_next;
    logic                  overflow_reg, overflow_next;
    logic                  push, pop, wr_en;

    // Status is derived purely from the registered level, so it never follows
    // in_valid or out_ready combinationally.
    assign level     = level_reg;
    assign full      = (level_reg == LEVEL_FULL);
    assign empty     = (level_reg == '0);
    assign out_valid = !empty;
    assign overflow  = overflow_reg;

    // The head is gated to zero while empty, so the stale contents of an
    // uncleared memory never show up on out_data.
    assign out_data = out_valid ? mem[rd_ptr_reg] : 8'h00;

    // Next-state logic for the pointers, level and the sticky overflow flag.
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        level_next    = level_reg;
        overflow_next = overflow_reg;
        wr_en         = 1'b0;
        push          = in_valid;
        pop           = out_valid && out_ready;

        if (push && pop) begin
            // A simultaneous push and pop leaves the level unchanged, even when
            // the buffer is full. At level 1 the new byte becomes the head.
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end else if (push && !full) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            level_next  = level_reg + 1'b1;
        end else if (push) begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
            // When full, wr_ptr equals rd_ptr, so this write replaces the
            // oldest byte. Both pointers then move forward together.
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            rd_ptr_next = rd_ptr_reg + 1'b1;
`else
            // The receiver cannot be stalled, so the new byte is lost here.
            wr_en       = 1'b0;
`endif
        end else if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
            level_next  = level_reg - 1'b1;
        end

        // When both happen in one cycle, setting overflow wins over clearing it.
        if (push && full && !pop) begin
            overflow_next = 1'b1;
        end else if (overflow_clr) begin
            overflow_next = 1'b0;
        end

        // A push that coincides with reset must not land in the buffer.
        if (rst) begin
            wr_en = 1'b0;
        end
    end

    // State register for the pointers, level and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage write port. It has no reset so that it can map onto memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

endmodule
